// File: rtl/mux_pkg.sv
// Shared defaults and width helper for the streaming channel multiplexer.
// Latency: n/a (compile-time constants and a constant function only).
// Backpressure: n/a.
package mux_pkg;

    localparam int NUM_CH_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Select / channel-id width: ceil(log2(num_ch)), never less than one bit.
    function automatic int sel_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/mux_stream_if.sv
// Bundle of the multiplexer's upstream and downstream handshake signals.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carried here; master drives the block, slave is the block.
//   din/sel/in_valid/in_ready : upstream offer (channel k at din[k*DATA_W +: DATA_W])
//   scan_mode                 : auto-scan request (meaningful only with MUX_SCAN_EN)
//   dout/out_ch/sel_err/out_valid/out_ready : registered downstream result
interface mux_stream_if
    import mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int SEL_W = sel_w(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] din;
    logic [SEL_W-1:0]         sel;
    logic                     in_valid;
    logic                     in_ready;
    logic                     scan_mode;
    logic [DATA_W-1:0]        dout;
    logic [SEL_W-1:0]         out_ch;
    logic                     sel_err;
    logic                     out_valid;
    logic                     out_ready;

    // Upstream/downstream agent driving the block.
    modport master (
        output din, sel, in_valid, scan_mode, out_ready,
        input  in_ready, dout, out_ch, sel_err, out_valid
    );

    // The multiplexer itself.
    modport slave (
        input  din, sel, in_valid, scan_mode, out_ready,
        output in_ready, dout, out_ch, sel_err, out_valid
    );

endinterface

// File: rtl/mux_scan_ptr.sv
// Wrapping channel counter for auto-scan: counts 0..NUM_CH-1 then back to 0.
// Latency: ptr advances on the edge after inc is sampled high.
// Backpressure: none; caller asserts inc only on an accepted transfer.
//   clk, rst_n : clock and asynchronous active-low reset (ptr clears to 0)
//   inc        : advance by one this cycle
//   ptr        : current scan channel, always < NUM_CH
module mux_scan_ptr
    import mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inc,
    output logic [sel_w(NUM_CH)-1:0]  ptr
);

    logic at_last;

    // Explicit wrap at NUM_CH-1 keeps the pointer in range even when
    // NUM_CH is not a power of two.
    assign at_last = (32'(ptr) == NUM_CH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= at_last ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mux_stream.sv
// Valid/ready N-to-1 channel multiplexer with one registered output stage.
// Latency: 1 cycle from accept to out_valid; full throughput, no bubble on drain+accept.
// Backpressure: in_ready = !out_valid || out_ready; output is held stable while stalled.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : mux_stream_if.slave (din/sel/in_valid/in_ready/scan_mode upstream,
//                dout/out_ch/sel_err/out_valid/out_ready downstream)
//   Build option MUX_SCAN_EN: adds auto-scan, where scan_mode=1 replaces sel by an
//   internal wrapping pointer that advances on each accept.
module mux_stream
    import mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_stream_if.slave bus
);

    localparam int SEL_W = sel_w(NUM_CH);

    logic              in_ready;
    logic              accept;
    logic [SEL_W-1:0]  eff_sel;
    logic              sel_oob;
    logic [DATA_W-1:0] sel_dat;
    logic [DATA_W-1:0] ch_dat [NUM_CH];

    logic              out_valid_q;
    logic [DATA_W-1:0] dout_q;
    logic [SEL_W-1:0]  out_ch_q;
    logic              sel_err_q;

    // The single output register may be refilled in the same cycle it drains.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

`ifdef MUX_SCAN_EN
    logic [SEL_W-1:0] scan_ptr;
    logic             scan_inc;

    // Pointer only moves on transfers taken in scan mode, so leaving scan
    // freezes it and re-entering resumes where it stopped.
    assign scan_inc = accept && bus.scan_mode;

    mux_scan_ptr #(
        .NUM_CH (NUM_CH)
    ) u_scan_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (scan_inc),
        .ptr   (scan_ptr)
    );

    assign eff_sel = bus.scan_mode ? scan_ptr : bus.sel;
`else
    logic unused_scan_mode;

    assign unused_scan_mode = bus.scan_mode;
    assign eff_sel          = bus.sel;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_dat[k] = bus.din[k*DATA_W +: DATA_W];
    end

    // Selects outside 0..NUM_CH-1 are reachable when NUM_CH is not a power
    // of two; they produce zero data and flag sel_err.
    assign sel_oob = (32'(eff_sel) >= NUM_CH);

    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (32'(eff_sel) == k) begin
                sel_dat = ch_dat[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            out_ch_q    <= '0;
            sel_err_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            dout_q      <= sel_oob ? '0 : sel_dat;
            out_ch_q    <= eff_sel;
            sel_err_q   <= sel_oob;
        end else if (bus.out_ready) begin
            // Drain with nothing new: payload fields keep their last value,
            // only the valid flag drops.
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_stream.sv
// Testbench for mux_stream: an 8-channel and a 6-channel instance share stimulus
// and are checked against a one-slot behavioural model of the output register.
// Scan-specific expectations follow the MUX_SCAN_EN build option.
module tb_mux_stream;
    import mux_pkg::*;

    localparam int DW = 8;
    localparam logic [63:0] DIN_REF = 64'h8877665544332211;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_stream_if #(.NUM_CH(8), .DATA_W(DW)) b8 ();
    mux_stream_if #(.NUM_CH(6), .DATA_W(DW)) b6 ();

    mux_stream #(.NUM_CH(8), .DATA_W(DW)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    mux_stream #(.NUM_CH(6), .DATA_W(DW)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

    int checks = 0;
    int errors = 0;

    // Model: index 0 = 8-channel instance, index 1 = 6-channel instance.
    int          nch [2] = '{8, 6};
    logic        m_vld  [2];
    logic [7:0]  m_dout [2];
    int          m_ch   [2];
    logic        m_err  [2];
    int          m_ptr  [2];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_vld[k]  = 1'b0;
            m_dout[k] = '0;
            m_ch[k]   = 0;
            m_err[k]  = 1'b0;
            m_ptr[k]  = 0;
        end
    endtask

    task automatic drive(input logic iv, input logic [2:0] s, input logic [63:0] d,
                         input logic orr, input logic sm);
        b8.in_valid  = iv;  b6.in_valid  = iv;
        b8.sel       = s;   b6.sel       = s;
        b8.din       = d;   b6.din       = d[47:0];
        b8.out_ready = orr; b6.out_ready = orr;
        b8.scan_mode = sm;  b6.scan_mode = sm;
    endtask

    // Drive one cycle's inputs, advance one rising edge, update the model,
    // and return 1 time unit after the edge.
    task automatic cyc(input logic iv, input logic [2:0] s, input logic [63:0] d,
                       input logic orr, input logic sm);
        logic acc;
        int   es;
        drive(iv, s, d, orr, sm);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            acc = iv && (!m_vld[k] || orr);
            if (acc) begin
                es = int'(s);
`ifdef MUX_SCAN_EN
                if (sm) begin
                    es       = m_ptr[k];
                    m_ptr[k] = (m_ptr[k] + 1) % nch[k];
                end
`endif
                m_vld[k]  = 1'b1;
                m_ch[k]   = es;
                m_err[k]  = (es >= nch[k]);
                m_dout[k] = m_err[k] ? 8'h00 : 8'((d >> (es * 8)) & 64'hFF);
            end else if (orr) begin
                m_vld[k] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 3'd0, 64'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_vld8 got %b exp 0", b8.out_valid); end
        checks++; if (b8.dout !== 8'h00) begin errors++; $display("FAIL reset_dout8 got %h exp 00", b8.dout); end
        checks++; if (b8.out_ch !== 3'd0) begin errors++; $display("FAIL reset_ch8 got %0d exp 0", b8.out_ch); end
        checks++; if (b8.sel_err !== 1'b0) begin errors++; $display("FAIL reset_err8 got %b exp 0", b8.sel_err); end
        checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy8 got %b exp 1", b8.in_ready); end
        checks++; if (b6.out_valid !== 1'b0 || b6.dout !== 8'h00) begin errors++; $display("FAIL reset_6 got vld %b dout %h exp 0 00", b6.out_valid, b6.dout); end
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_rdy got %b exp 1", b8.in_ready); end
    endtask

    task automatic test_basic();
        cyc(1'b1, 3'd3, DIN_REF, 1'b1, 1'b0);
        checks++; if (b8.dout !== 8'h44) begin errors++; $display("FAIL basic_dout got %h exp 44", b8.dout); end
        checks++; if (b8.out_ch !== 3'd3) begin errors++; $display("FAIL basic_ch got %0d exp 3", b8.out_ch); end
        checks++; if (b8.out_valid !== 1'b1) begin errors++; $display("FAIL basic_vld got %b exp 1", b8.out_valid); end
        checks++; if (b8.sel_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", b8.sel_err); end
        checks++; if (b6.dout !== 8'h44) begin errors++; $display("FAIL basic_dout6 got %h exp 44", b6.dout); end
    endtask

    task automatic test_stall();
        // Output holds 0x44 from test_basic; stall five cycles with a live offer and noisy din.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 3'd7, {$urandom, $urandom}, 1'b0, 1'b0);
            checks++; if (b8.dout !== 8'h44 || b8.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got vld %b dout %h exp 1 44", i, b8.out_valid, b8.dout); end
            checks++; if (b8.in_ready !== 1'b0) begin errors++; $display("FAIL stall_rdy[%0d] got %b exp 0", i, b8.in_ready); end
            checks++; if (b8.out_ch !== 3'd3) begin errors++; $display("FAIL stall_ch[%0d] got %0d exp 3", i, b8.out_ch); end
        end
        cyc(1'b1, 3'd7, DIN_REF, 1'b1, 1'b0);
        checks++; if (b8.dout !== 8'h88 || b8.out_valid !== 1'b1) begin errors++; $display("FAIL stall_release got vld %b dout %h exp 1 88", b8.out_valid, b8.dout); end
        checks++; if (b8.out_ch !== 3'd7) begin errors++; $display("FAIL stall_release_ch got %0d exp 7", b8.out_ch); end
        cyc(1'b0, 3'd0, 64'd0, 1'b1, 1'b0);
        checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL drain_vld got %b exp 0", b8.out_valid); end
    endtask

    task automatic test_sel_err();
        cyc(1'b1, 3'd6, DIN_REF, 1'b1, 1'b0);
        checks++; if (b6.dout !== 8'h00) begin errors++; $display("FAIL err_dout6 got %h exp 00", b6.dout); end
        checks++; if (b6.sel_err !== 1'b1) begin errors++; $display("FAIL err_flag6 got %b exp 1", b6.sel_err); end
        checks++; if (b6.out_ch !== 3'd6) begin errors++; $display("FAIL err_ch6 got %0d exp 6", b6.out_ch); end
        checks++; if (b8.dout !== 8'h77 || b8.sel_err !== 1'b0) begin errors++; $display("FAIL err_dout8 got %h/%b exp 77/0", b8.dout, b8.sel_err); end
        cyc(1'b1, 3'd2, DIN_REF, 1'b1, 1'b0);
        checks++; if (b6.sel_err !== 1'b0) begin errors++; $display("FAIL err_clear6 got %b exp 0", b6.sel_err); end
        checks++; if (b6.dout !== 8'h33 || b6.out_ch !== 3'd2) begin errors++; $display("FAIL err_next6 got %h/%0d exp 33/2", b6.dout, b6.out_ch); end
        cyc(1'b1, 3'd7, DIN_REF, 1'b1, 1'b0);
        checks++; if (b6.sel_err !== 1'b1 || b6.dout !== 8'h00) begin errors++; $display("FAIL err_sel7_6 got %b/%h exp 1/00", b6.sel_err, b6.dout); end
        cyc(1'b0, 3'd0, 64'd0, 1'b1, 1'b0);
    endtask

`ifdef MUX_SCAN_EN
    task automatic test_scan();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, 1'b1, 1'b1);
            checks++; if (int'(b8.out_ch) !== i % 8) begin errors++; $display("FAIL scan_ch8[%0d] got %0d exp %0d", i, b8.out_ch, i % 8); end
            checks++; if (int'(b6.out_ch) !== i % 6) begin errors++; $display("FAIL scan_ch6[%0d] got %0d exp %0d", i, b6.out_ch, i % 6); end
            checks++; if (b6.sel_err !== 1'b0 || b8.sel_err !== 1'b0) begin errors++; $display("FAIL scan_err[%0d] got %b/%b exp 0/0", i, b8.sel_err, b6.sel_err); end
            checks++; if (b6.dout !== m_dout[1]) begin errors++; $display("FAIL scan_dout6[%0d] got %h exp %h", i, b6.dout, m_dout[1]); end
        end
        cyc(1'b1, 3'd5, DIN_REF, 1'b1, 1'b0);
        checks++; if (b8.out_ch !== 3'd5 || b8.dout !== 8'h66) begin errors++; $display("FAIL scan_off got %0d/%h exp 5/66", b8.out_ch, b8.dout); end
        cyc(1'b1, 3'd0, DIN_REF, 1'b1, 1'b1);
        checks++; if (b8.out_ch !== 3'd2) begin errors++; $display("FAIL scan_resume8 got %0d exp 2", b8.out_ch); end
        checks++; if (b6.out_ch !== 3'd4) begin errors++; $display("FAIL scan_resume6 got %0d exp 4", b6.out_ch); end
        cyc(1'b0, 3'd0, 64'd0, 1'b1, 1'b0);
    endtask
`else
    task automatic test_no_scan();
        cyc(1'b1, 3'd5, DIN_REF, 1'b1, 1'b1);
        checks++; if (b8.out_ch !== 3'd5 || b8.dout !== 8'h66) begin errors++; $display("FAIL noscan8 got %0d/%h exp 5/66", b8.out_ch, b8.dout); end
        checks++; if (b6.out_ch !== 3'd5 || b6.dout !== 8'h66) begin errors++; $display("FAIL noscan6 got %0d/%h exp 5/66", b6.out_ch, b6.dout); end
        cyc(1'b0, 3'd0, 64'd0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_reset_mid_stall();
        cyc(1'b1, 3'd4, DIN_REF, 1'b1, 1'b0);
        cyc(1'b0, 3'd0, 64'd0, 1'b0, 1'b0);
        checks++; if (b8.out_valid !== 1'b1 || b8.dout !== 8'h55) begin errors++; $display("FAIL mid_pre got %b/%h exp 1/55", b8.out_valid, b8.dout); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (b8.out_valid !== 1'b0 || b8.dout !== 8'h00) begin errors++; $display("FAIL mid_async8 got %b/%h exp 0/00", b8.out_valid, b8.dout); end
        checks++; if (b6.out_valid !== 1'b0 || b6.dout !== 8'h00) begin errors++; $display("FAIL mid_async6 got %b/%h exp 0/00", b6.out_valid, b6.dout); end
        checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rdy got %b exp 1", b8.in_ready); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rdy_after got %b exp 1", b8.in_ready); end
        cyc(1'b0, 3'd0, 64'd0, 1'b1, 1'b0);
        checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL mid_replay got %b exp 0", b8.out_valid); end
        cyc(1'b1, 3'd6, DIN_REF, 1'b1, 1'b1);
`ifdef MUX_SCAN_EN
        checks++; if (b8.out_ch !== 3'd0 || b6.out_ch !== 3'd0) begin errors++; $display("FAIL mid_ptr got %0d/%0d exp 0/0", b8.out_ch, b6.out_ch); end
`else
        checks++; if (b8.out_ch !== 3'd6 || b8.dout !== 8'h77) begin errors++; $display("FAIL mid_sel got %0d/%h exp 6/77", b8.out_ch, b8.dout); end
`endif
        cyc(1'b0, 3'd0, 64'd0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic       iv, orr, sm;
        logic [2:0] s;
        logic       o_vld [2];
        logic       o_rdy [2];
        logic [7:0] o_dout [2];
        logic [2:0] o_ch [2];
        logic       o_err [2];
        for (int i = 0; i < 400; i++) begin
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 2) != 0);
            sm  = 1'($urandom_range(0, 1));
            s   = 3'($urandom_range(0, 7));
            cyc(iv, s, {$urandom, $urandom}, orr, sm);
            o_vld[0] = b8.out_valid; o_vld[1] = b6.out_valid;
            o_rdy[0] = b8.in_ready;  o_rdy[1] = b6.in_ready;
            o_dout[0] = b8.dout;     o_dout[1] = b6.dout;
            o_ch[0] = b8.out_ch;     o_ch[1] = b6.out_ch;
            o_err[0] = b8.sel_err;   o_err[1] = b6.sel_err;
            for (int k = 0; k < 2; k++) begin
                checks++; if (o_vld[k] !== m_vld[k]) begin errors++; $display("FAIL rnd_vld[%0d] dut%0d got %b exp %b", i, nch[k], o_vld[k], m_vld[k]); end
                checks++; if (o_rdy[k] !== (!m_vld[k] || orr)) begin errors++; $display("FAIL rnd_rdy[%0d] dut%0d got %b exp %b", i, nch[k], o_rdy[k], !m_vld[k] || orr); end
                if (m_vld[k]) begin
                    checks++; if (o_dout[k] !== m_dout[k]) begin errors++; $display("FAIL rnd_dout[%0d] dut%0d got %h exp %h", i, nch[k], o_dout[k], m_dout[k]); end
                    checks++; if (int'(o_ch[k]) !== m_ch[k]) begin errors++; $display("FAIL rnd_ch[%0d] dut%0d got %0d exp %0d", i, nch[k], o_ch[k], m_ch[k]); end
                    checks++; if (o_err[k] !== m_err[k]) begin errors++; $display("FAIL rnd_err[%0d] dut%0d got %b exp %b", i, nch[k], o_err[k], m_err[k]); end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_stall();
        test_sel_err();
`ifdef MUX_SCAN_EN
        test_scan();
`else
        test_no_scan();
`endif
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_stream.md
MUX_STREAM -- requirements
Module: mux_stream

Interface
REQ-001 Parameter NUM_CH, default 8, number of input channels (2..64).
REQ-002 Parameter DATA_W, default 8, width of each channel in bits (1..64).
REQ-003 Localparam SEL_W = max(1, clog2(NUM_CH)), select and channel-id width.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 din  input  NUM_CH*DATA_W  packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 sel  input  SEL_W  channel select, sampled only on an accepted transfer.
REQ-008 in_valid  input  1  upstream offers din/sel.
REQ-009 in_ready  output  1  block can accept this cycle.
REQ-010 scan_mode  input  1  selects auto-scan; ignored when MUX_SCAN_EN is undefined.
REQ-011 dout  output  DATA_W  registered selected channel.
REQ-012 out_ch  output  SEL_W  channel index that produced dout.
REQ-013 sel_err  output  1  set when the captured select was >= NUM_CH.
REQ-014 out_valid  output  1  dout, out_ch and sel_err are valid.
REQ-015 out_ready  input  1  downstream accepts this cycle.

Function
REQ-016 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-017 Accept SHALL occur when in_valid && in_ready.
REQ-018 On accept, the next edge SHALL load dout = channel[eff_sel], out_ch = eff_sel and out_valid = 1 (latency 1 cycle).
REQ-019 eff_sel SHALL be sel, or scan_ptr when scan is active.
REQ-020 If eff_sel >= NUM_CH, dout SHALL load 0 and sel_err SHALL load 1; otherwise sel_err SHALL load 0.
REQ-021 With out_valid=1 && out_ready=1 && no accept, out_valid SHALL clear on the next edge.
REQ-022 Simultaneous drain and accept SHALL load the new data with out_valid held at 1, with no bubble.
REQ-023 While out_valid=1 && out_ready=0, dout, out_ch and sel_err SHALL hold stable.
REQ-024 in_valid=1 with no accept SHALL change no state.
REQ-025 din changes between accepts SHALL NOT affect dout.

Reset
REQ-026 While rst_n=0: out_valid=0, dout=0, out_ch=0, sel_err=0, scan_ptr=0, effective asynchronously.
REQ-027 in_ready SHALL be 1 during and immediately after reset.
REQ-028 Reset asserted mid-stall SHALL discard held data; no transfer SHALL be replayed.

Configuration
REQ-029 Macro MUX_SCAN_EN SHALL compile in the auto-scan feature.
REQ-030 With MUX_SCAN_EN and scan_mode=1, eff_sel SHALL be scan_ptr and sel SHALL be ignored.
REQ-031 In scan, scan_ptr SHALL increment on each accept and wrap from NUM_CH-1 to 0.
REQ-032 scan_ptr SHALL never reach an index >= NUM_CH, so sel_err SHALL always be 0 in scan.
REQ-033 With scan_mode=0, scan_ptr SHALL hold its value; re-entering scan SHALL resume from it.
REQ-034 Without MUX_SCAN_EN, no scan_ptr logic SHALL exist, scan_mode SHALL be unused, and eff_sel SHALL be sel.

Structure
REQ-035 Package mux_pkg SHALL hold the NUM_CH/DATA_W defaults and a function computing SEL_W.
REQ-036 Sub-module mux_scan_ptr (wrap counter: clk, rst_n, inc, ptr) SHALL implement scan_ptr.
REQ-037 mux_scan_ptr SHALL be instantiated only under MUX_SCAN_EN.

Verification
REQ-038 NUM_CH=8, DATA_W=8, din=0x8877665544332211, sel=3, in_valid=1, out_ready=1 -> next cycle dout=0x44, out_ch=3, out_valid=1, sel_err=0.
REQ-039 out_ready=0 after load of 0x44 -> in_ready=0 and dout holds 0x44 for 5 cycles; then out_ready=1 with new sel=7 -> dout=0x88 with no idle cycle.
REQ-040 NUM_CH=6, sel=6 -> dout=0, sel_err=1, out_ch=6; next accept with sel=2 -> sel_err=0.
REQ-041 MUX_SCAN_EN, NUM_CH=8, scan_mode=1, 10 back-to-back accepts -> out_ch sequence 0..7,0,1; sel ignored.
REQ-042 Assert rst_n=0 while out_valid=1 and stalled -> out_valid=0, dout=0 immediately (asynchronously); after release, scan_ptr=0 and in_ready=1.
REQ-043 Build without MUX_SCAN_EN, scan_mode=1, sel=5 -> out_ch=5 (scan inactive).
